pbs_ctrl: RTL and testbench

//  Turn-sequencing controller for the battle datapath: drives target/p_move/actr/calc_dmg/app_dmg.

---
 rtl/pbs_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pbs_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbs_ctrl.sv
// Turn-sequencing controller for the battle datapath: player half-turn, then AI half-turn,
// with an HP check after each half and a latched game-over state.
module pbs_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TURN_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        move_in,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [3:0]        p_hp,
  input  logic [3:0]        AI_hp,
  output logic              target,
  output logic [1:0]        p_move,
  output logic              actr,
  output logic              calc_dmg,
  output logic              app_dmg,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              game_over,
  output logic              winner
);

  localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
  localparam logic [TURN_W-1:0] TURN_MAX    = {TURN_W{1'b1}};
  localparam logic [TURN_W-1:0] TURN_ONE    = TURN_W'(1'b1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_MOVE = 4'd1,
    P_SEL     = 4'd2,
    P_CALC    = 4'd3,
    P_APPLY   = 4'd4,
    P_SETTLE  = 4'd5,
    AI_SEL    = 4'd6,
    AI_CALC   = 4'd7,
    AI_APPLY  = 4'd8,
    AI_SETTLE = 4'd9,
    OVER      = 4'd10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] settle_cnt_r;
  logic             settle_done_s;
  logic             in_settle_s;
  logic             take_move_s;
  logic             player_win_s;
  logic             ai_win_s;
  logic             turn_inc_s;

  // Next-state decode plus the one-cycle event flags derived from it.
  always_comb begin
    state_s       = state_r;
    settle_done_s = (settle_cnt_r == SETTLE_LAST);
    in_settle_s   = 1'b0;
    take_move_s   = 1'b0;
    player_win_s  = 1'b0;
    ai_win_s      = 1'b0;
    turn_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_s = WAIT_MOVE;
        else       state_s = IDLE;
      end
      WAIT_MOVE: begin
        if (move_valid && move_ready) begin
          take_move_s = 1'b1;
          state_s     = P_SEL;
        end else begin
          state_s = WAIT_MOVE;
        end
      end
      P_SEL:   state_s = P_CALC;
      P_CALC:  state_s = P_APPLY;
      P_APPLY: state_s = P_SETTLE;
      P_SETTLE: begin
        in_settle_s = 1'b1;
        // Only the half-turn's own victim is checked, so a double KO favours the mover.
        if (settle_done_s) begin
          if (AI_hp == 4'd0) begin
            player_win_s = 1'b1;
            state_s      = OVER;
          end else begin
            state_s = AI_SEL;
          end
        end else begin
          state_s = P_SETTLE;
        end
      end
      AI_SEL:   state_s = AI_CALC;
      AI_CALC:  state_s = AI_APPLY;
      AI_APPLY: state_s = AI_SETTLE;
      AI_SETTLE: begin
        in_settle_s = 1'b1;
        if (settle_done_s) begin
          if (p_hp == 4'd0) begin
            ai_win_s = 1'b1;
            state_s  = OVER;
          end else begin
            turn_inc_s = 1'b1;
            state_s    = WAIT_MOVE;
          end
        end else begin
          state_s = AI_SETTLE;
        end
      end
      OVER:    state_s = OVER;
      default: state_s = IDLE;
    endcase
  end

  // State register and settle-window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (in_settle_s && !settle_done_s) settle_cnt_r <= settle_cnt_r + CNT_ONE;
      else                               settle_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Output registers decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_ready <= 1'b0;
      target     <= 1'b0;
      p_move     <= 2'b00;
      actr       <= 1'b0;
      calc_dmg   <= 1'b0;
      app_dmg    <= 1'b0;
      turn_cnt   <= {TURN_W{1'b0}};
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      move_ready <= (state_s == WAIT_MOVE);
      calc_dmg   <= (state_s == P_CALC)  || (state_s == AI_CALC);
      app_dmg    <= (state_s == P_APPLY) || (state_s == AI_APPLY);
      game_over  <= (state_s == OVER);
      // target is frozen for a whole half-turn because the datapath writes through it every clock.
      if ((state_s == P_SEL) || (state_s == P_CALC) || (state_s == P_APPLY) || (state_s == P_SETTLE))
        target <= 1'b1;
      else if ((state_s == AI_SEL) || (state_s == AI_CALC) || (state_s == AI_APPLY) || (state_s == AI_SETTLE))
        target <= 1'b0;
      else
        target <= target;
      if (state_s == P_SEL)       actr <= 1'b0;
      else if (state_s == AI_SEL) actr <= 1'b1;
      else                        actr <= actr;
      if (take_move_s) p_move <= move_in;
      else             p_move <= p_move;
      if (turn_inc_s && (turn_cnt != TURN_MAX)) turn_cnt <= turn_cnt + TURN_ONE;
      else                                      turn_cnt <= turn_cnt;
      if (player_win_s)  winner <= 1'b1;
      else if (ai_win_s) winner <= 1'b0;
      else               winner <= winner;
    end
  end

endmodule

// File: tb/tb_pbs_ctrl.sv
// Bench for pbs_ctrl: two instances (default settle, and SETTLE_CYCLES=4/TURN_W=2) checked
// every cycle against a phase-count model, plus directed literal expectations.
module tb_pbs_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, mvv_a, mr_a, tg_a, ac_a, cd_a, ad_a, go_a, wn_a;
  logic [1:0] mvin_a, pm_a;
  logic [3:0] php_a, aihp_a;
  logic [7:0] tc_a;
  logic       rst_b, start_b, mvv_b, mr_b, tg_b, ac_b, cd_b, ad_b, go_b, wn_b;
  logic [1:0] mvin_b, pm_b;
  logic [3:0] php_b, aihp_b;
  logic [1:0] tc_b;

  int errors = 0;
  int checks = 0;

  pbs_ctrl #(.SETTLE_CYCLES(2), .TURN_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .move_in(mvin_a), .move_valid(mvv_a),
    .move_ready(mr_a), .p_hp(php_a), .AI_hp(aihp_a), .target(tg_a), .p_move(pm_a),
    .actr(ac_a), .calc_dmg(cd_a), .app_dmg(ad_a), .turn_cnt(tc_a), .game_over(go_a), .winner(wn_a)
  );

  pbs_ctrl #(.SETTLE_CYCLES(4), .TURN_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .move_in(mvin_b), .move_valid(mvv_b),
    .move_ready(mr_b), .p_hp(php_b), .AI_hp(aihp_b), .target(tg_b), .p_move(pm_b),
    .actr(ac_b), .calc_dmg(cd_b), .app_dmg(ad_b), .turn_cnt(tc_b), .game_over(go_b), .winner(wn_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, -1 waiting for a move, -2 battle over, k>0 = k-th cycle after the handshake.
  // A half-turn lasts h = 3 + SETTLE_CYCLES cycles; cycle 2 of a half is calc, cycle 3 is apply.
  int         m_phase[2];
  int         m_turn[2];
  logic [1:0] m_pmove[2];
  logic       m_target[2], m_actr[2], m_winner[2];
  int         m_h[2]    = '{5, 7};
  int         m_tmax[2] = '{255, 3};

  task automatic model_step(input int d, input logic r, input logic st, input logic mv,
                            input logic [1:0] mi, input logic [3:0] ph, input logic [3:0] ah);
    int h;
    h = m_h[d];
    if (r) begin
      m_phase[d] = 0; m_turn[d] = 0; m_pmove[d] = 2'b00;
      m_target[d] = 1'b0; m_actr[d] = 1'b0; m_winner[d] = 1'b0;
    end else if (m_phase[d] == 0) begin
      if (st) m_phase[d] = -1;
    end else if (m_phase[d] == -1) begin
      if (mv) begin
        m_pmove[d] = mi;
        m_phase[d] = 1;
      end
    end else if (m_phase[d] == -2) begin
      m_phase[d] = -2;
    end else if (m_phase[d] == h) begin
      if (ah == 4'd0) begin m_phase[d] = -2; m_winner[d] = 1'b1; end
      else m_phase[d] = h + 1;
    end else if (m_phase[d] == 2 * h) begin
      if (ph == 4'd0) begin m_phase[d] = -2; m_winner[d] = 1'b0; end
      else begin
        if (m_turn[d] < m_tmax[d]) m_turn[d]++;
        m_phase[d] = -1;
      end
    end else begin
      m_phase[d]++;
    end
    if (m_phase[d] > 0) begin
      m_target[d] = (m_phase[d] <= h);
      m_actr[d]   = (m_phase[d] > h);
    end
  endtask

  task automatic compare(input int d, input logic mr, input logic tg, input logic [1:0] pm,
                         input logic ac, input logic cd, input logic ad, input logic [7:0] tc,
                         input logic go, input logic wn);
    int j;
    j = (m_phase[d] > m_h[d]) ? m_phase[d] - m_h[d] : m_phase[d];
    chk($sformatf("d%0d move_ready", d), mr, m_phase[d] == -1);
    chk($sformatf("d%0d calc_dmg", d), cd, (m_phase[d] > 0) && (j == 2));
    chk($sformatf("d%0d app_dmg", d), ad, (m_phase[d] > 0) && (j == 3));
    chk($sformatf("d%0d game_over", d), go, m_phase[d] == -2);
    chk($sformatf("d%0d target", d), tg, m_target[d]);
    chk($sformatf("d%0d actr", d), ac, m_actr[d]);
    chk($sformatf("d%0d p_move", d), pm, m_pmove[d]);
    chk($sformatf("d%0d turn_cnt", d), tc, m_turn[d]);
    if (m_phase[d] == -2) chk($sformatf("d%0d winner", d), wn, m_winner[d]);
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, start_a, mvv_a, mvin_a, php_a, aihp_a);
    model_step(1, rst_b, start_b, mvv_b, mvin_b, php_b, aihp_b);
    #1;
    compare(0, mr_a, tg_a, pm_a, ac_a, cd_a, ad_a, tc_a, go_a, wn_a);
    compare(1, mr_b, tg_b, pm_b, ac_b, cd_b, ad_b, {6'd0, tc_b}, go_b, wn_b);
  end

  task automatic handshake(input int d, input logic [1:0] v);
    if (d == 0) begin mvin_a = v; mvv_a = 1'b1; end
    else        begin mvin_b = v; mvv_b = 1'b1; end
    @(negedge clk);
    mvv_a = 1'b0;
    mvv_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; mvv_a = 1'b0; mvin_a = 2'b00; php_a = 4'd5; aihp_a = 4'd5;
    rst_b = 1'b1; start_b = 1'b0; mvv_b = 1'b0; mvin_b = 2'b00; php_b = 4'd5; aihp_b = 4'd5;
    repeat (2) @(negedge clk);
    chk("reset move_ready", mr_a, 1'b0);
    chk("reset target", tg_a, 1'b0);
    chk("reset turn_cnt", tc_a, 8'd0);
    chk("reset game_over", go_a, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Test 1: one full turn with move 2'b10.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t1 ready in wait", mr_a, 1'b1);
    handshake(0, 2'b10);
    chk("t1 ready dropped", mr_a, 1'b0);
    chk("t1 p_move", pm_a, 2'b10);
    chk("t1 sel actr", ac_a, 1'b0);
    chk("t1 sel target", tg_a, 1'b1);
    @(negedge clk);
    chk("t1 calc", cd_a, 1'b1);
    @(negedge clk);
    chk("t1 apply", ad_a, 1'b1);
    chk("t1 calc low at apply", cd_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1 ai sel actr", ac_a, 1'b1);
    chk("t1 ai sel target", tg_a, 1'b0);
    repeat (5) @(negedge clk);
    chk("t1 turn_cnt", tc_a, 8'd1);
    chk("t1 back to wait", mr_a, 1'b1);

    // Test 4: move_valid pulses during P_CALC and AI_APPLY are ignored.
    handshake(0, 2'b01);
    @(negedge clk);
    mvin_a = 2'b11; mvv_a = 1'b1;
    @(negedge clk);
    mvv_a = 1'b0;
    chk("t4 apply unaffected", ad_a, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4 ai apply", ad_a, 1'b1);
    mvin_a = 2'b00; mvv_a = 1'b1;
    @(negedge clk);
    mvv_a = 1'b0;
    chk("t4 p_move held", pm_a, 2'b01);
    repeat (2) @(negedge clk);
    chk("t4 turn_cnt", tc_a, 8'd2);

    // Test 2: both HP zero at the player compare -> player wins, no AI half.
    handshake(0, 2'b11);
    aihp_a = 4'd0; php_a = 4'd0;
    repeat (4) @(negedge clk);
    chk("t2 not over before compare", go_a, 1'b0);
    @(negedge clk);
    chk("t2 game_over", go_a, 1'b1);
    chk("t2 winner", wn_a, 1'b1);
    chk("t2 turn_cnt", tc_a, 8'd2);
    chk("t2 no ai sel", ac_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2 still over", go_a, 1'b1);

    // Test 3: p_hp zero at the AI compare -> AI wins; start/move_valid ignored afterwards.
    rst_a = 1'b1;
    @(negedge clk);
    chk("t3 reset game_over", go_a, 1'b0);
    chk("t3 reset p_move", pm_a, 2'b00);
    chk("t3 reset turn_cnt", tc_a, 8'd0);
    rst_a = 1'b0; aihp_a = 4'd5; php_a = 4'd5;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    handshake(0, 2'b00);
    php_a = 4'd0;
    repeat (10) @(negedge clk);
    chk("t3 game_over", go_a, 1'b1);
    chk("t3 winner", wn_a, 1'b0);
    chk("t3 turn_cnt", tc_a, 8'd0);
    start_a = 1'b1; mvv_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3 over sticky", go_a, 1'b1);
    chk("t3 no ready", mr_a, 1'b0);
    start_a = 1'b0; mvv_a = 1'b0;

    // Test 5: reset during AI_APPLY.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; php_a = 4'd5;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    handshake(0, 2'b10);
    repeat (7) @(negedge clk);
    chk("t5 in ai apply", ad_a, 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("t5 app_dmg cleared", ad_a, 1'b0);
    chk("t5 actr cleared", ac_a, 1'b0);
    chk("t5 p_move cleared", pm_a, 2'b00);
    repeat (3) @(negedge clk);
    chk("t5 idle no ready", mr_a, 1'b0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t5 resumed", mr_a, 1'b1);

    // Test 6: SETTLE_CYCLES=4, TURN_W=2 instance.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    handshake(1, 2'b01);
    repeat (2) @(negedge clk);
    chk("t6 apply", ad_b, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6 still settling target", tg_b, 1'b1);
    chk("t6 still settling actr", ac_b, 1'b0);
    @(negedge clk);
    chk("t6 ai sel after 4", ac_b, 1'b1);
    repeat (7) @(negedge clk);
    chk("t6 turn 1", tc_b, 2'd1);
    handshake(1, 2'b10);
    repeat (14) @(negedge clk);
    chk("t6 turn 2", tc_b, 2'd2);
    for (int t = 3; t <= 5; t++) begin
      handshake(1, 2'b11);
      repeat (14) @(negedge clk);
      chk($sformatf("t6 turn %0d saturated", t), tc_b, 2'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
